// File: rtl/video_effects_pkg.sv
// Shared constants for the video_effects frame controller: register map, effect bits, FSM states.
package video_effects_pkg;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrDelc   = 2'd1;
  localparam logic [1:0] AddrSubc   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  localparam int unsigned EffDelete = 0;
  localparam int unsigned EffSubst  = 1;
  localparam int unsigned EffQuant  = 2;
  localparam int unsigned EffGray   = 3;
  localparam int unsigned EffNeg    = 4;

  localparam int unsigned CtrlEnBit     = 8;
  localparam int unsigned CtrlPendBit   = 31;
  localparam int unsigned StatFrameBit  = 16;
  localparam int unsigned StatIrqBit    = 17;
  localparam int unsigned StatSopErrBit = 18;

  typedef enum logic [0:0] {
    StWaitSop = 1'b0,
    StInFrame = 1'b1
  } state_e;

endpackage

// File: rtl/video_effects_ctrl_if.sv
// Bundles the Avalon-MM register bus, Avalon-ST sink/source and datapath config of the controller.
interface video_effects_ctrl_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned EFF_W = 5
) ();
  logic [1:0]       avs_address;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic             avs_read;
  logic [31:0]      avs_readdata;
  logic [DW-1:0]    snk_data;
  logic             snk_startofpacket;
  logic             snk_endofpacket;
  logic             snk_valid;
  logic             snk_ready;
  logic [DW-1:0]    src_data;
  logic             src_startofpacket;
  logic             src_endofpacket;
  logic             src_valid;
  logic             src_ready;
  logic [EFF_W-1:0] fx_effect;
  logic [DW-1:0]    fx_delete_color;
  logic [DW-1:0]    fx_substitute_color;
  logic [DW-1:0]    fx_data_in;
  logic [DW-1:0]    fx_data_out;
  logic             irq;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata,
    input  snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
    output snk_ready,
    output src_data, src_startofpacket, src_endofpacket, src_valid,
    input  src_ready,
    output fx_effect, fx_delete_color, fx_substitute_color, fx_data_in,
    input  fx_data_out,
    output irq
  );

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata,
    output snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
    input  snk_ready,
    input  src_data, src_startofpacket, src_endofpacket, src_valid,
    output src_ready,
    input  fx_effect, fx_delete_color, fx_substitute_color, fx_data_in,
    output fx_data_out,
    input  irq
  );
endinterface

// File: rtl/video_effects_ctrl_regs.sv
// Avalon-MM shadow register file with pending / W1C status flags and registered read mux.
// Interrupt flag exists only when VIDEO_EFFECTS_CTRL_IRQ_EN is defined.
module video_effects_ctrl_regs
  import video_effects_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned EFF_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             commit,
  input  logic             sop_err_set,
  input  logic             irq_set,
  input  logic             in_frame,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic [CNT_W-1:0] drop_cnt,
  output logic [EFF_W-1:0] sh_eff,
  output logic             sh_en,
  output logic [DW-1:0]    sh_delc,
  output logic [DW-1:0]    sh_subc,
  output logic             irq
);

  logic             cfg_wr, st_wr;
  logic             pending_q, pending_d;
  logic             sop_err_q, sop_err_d;
  logic             irq_pend;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic [EFF_W-1:0] eff_q;
  logic             en_q;
  logic [DW-1:0]    delc_q, subc_q;
  logic             unused_sig;

  assign cfg_wr = avs_write & (avs_address != AddrStatus);
  assign st_wr  = avs_write & (avs_address == AddrStatus);

  // A write coinciding with a commit keeps pending so the new value lands next frame.
  always_comb begin
    pending_d = pending_q;
    if (cfg_wr) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  assign sop_err_d = sop_err_set | (sop_err_q & ~(st_wr & avs_writedata[StatSopErrBit]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eff_q     <= '0;
      en_q      <= 1'b0;
      delc_q    <= '0;
      subc_q    <= '0;
      pending_q <= 1'b0;
      sop_err_q <= 1'b0;
    end else begin
      if (avs_write && avs_address == AddrCtrl) begin
        eff_q <= avs_writedata[EFF_W-1:0];
        en_q  <= avs_writedata[CtrlEnBit];
      end
      if (avs_write && avs_address == AddrDelc) delc_q <= avs_writedata[DW-1:0];
      if (avs_write && avs_address == AddrSubc) subc_q <= avs_writedata[DW-1:0];
      pending_q <= pending_d;
      sop_err_q <= sop_err_d;
    end
  end

`ifdef VIDEO_EFFECTS_CTRL_IRQ_EN
  logic irq_pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_set | (irq_pend_q & ~(st_wr & avs_writedata[StatIrqBit]));
    end
  end

  assign irq_pend = irq_pend_q;
`else
  assign irq_pend = 1'b0;
`endif

  assign irq = irq_pend;

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      AddrCtrl: begin
        rd_mux[EFF_W-1:0]  = eff_q;
        rd_mux[CtrlEnBit]   = en_q;
        rd_mux[CtrlPendBit] = pending_q;
      end
      AddrDelc: rd_mux[DW-1:0] = delc_q;
      AddrSubc: rd_mux[DW-1:0] = subc_q;
      AddrStatus: begin
        rd_mux[15:0]          = frame_cnt[15:0];
        rd_mux[StatFrameBit]  = in_frame;
        rd_mux[StatIrqBit]    = irq_pend;
        rd_mux[StatSopErrBit] = sop_err_q;
        rd_mux[31:24]         = drop_cnt[7:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (avs_read) begin
      readdata_q <= rd_mux;
    end
  end

  assign avs_readdata = readdata_q;
  assign sh_eff       = eff_q;
  assign sh_en        = en_q;
  assign sh_delc      = delc_q;
  assign sh_subc      = subc_q;

  assign unused_sig = ^{avs_writedata[31:19], avs_writedata[17:16], drop_cnt, frame_cnt, irq_set};

endmodule

// File: rtl/video_effects_ctrl.sv
// Frame-synchronous controller: stream pipeline, frame FSM, counters and SOP-aligned config commit.
// Optional frame-done interrupt via VIDEO_EFFECTS_CTRL_IRQ_EN.
module video_effects_ctrl
  import video_effects_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned EFF_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                reset_n,
  video_effects_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             adv, accept, commit, fwd, fwd_eop, drop, sop_err_set;
  logic             src_valid_q, src_sop_q, src_eop_q;
  logic [DW-1:0]    last_in_q;
  logic [EFF_W-1:0] cm_eff_q, sh_eff, sh_eff_gated;
  logic [DW-1:0]    cm_delc_q, cm_subc_q, sh_delc, sh_subc;
  logic             sh_en;
  logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;

  assign adv     = bus.src_ready | ~src_valid_q;
  assign accept  = bus.snk_valid & adv;
  assign commit  = accept & bus.snk_startofpacket;
  assign fwd_eop = accept & fwd & bus.snk_endofpacket;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitSop;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitSop: if (commit && !bus.snk_endofpacket) state_d = StInFrame;
      StInFrame: if (accept && bus.snk_endofpacket) state_d = StWaitSop;
    endcase
  end

  always_comb begin
    fwd         = 1'b1;
    drop        = 1'b0;
    sop_err_set = 1'b0;
    unique case (state_q)
      StWaitSop: begin
        fwd  = bus.snk_startofpacket;
        drop = accept & ~bus.snk_startofpacket;
      end
      StInFrame: sop_err_set = commit;
    endcase
  end

  // Disabled effects are committed as plain pass-through.
  assign sh_eff_gated = sh_en ? sh_eff : '0;

  assign bus.fx_effect           = commit ? sh_eff_gated : cm_eff_q;
  assign bus.fx_delete_color     = commit ? sh_delc : cm_delc_q;
  assign bus.fx_substitute_color = commit ? sh_subc : cm_subc_q;
  assign bus.fx_data_in          = adv ? bus.snk_data : last_in_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cm_eff_q    <= '0;
      cm_delc_q   <= '0;
      cm_subc_q   <= '0;
      last_in_q   <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (commit) begin
        cm_eff_q  <= sh_eff_gated;
        cm_delc_q <= sh_delc;
        cm_subc_q <= sh_subc;
      end
      if (accept) last_in_q <= bus.snk_data;
      if (adv) begin
        src_valid_q <= accept & fwd;
        src_sop_q   <= bus.snk_startofpacket;
        src_eop_q   <= bus.snk_endofpacket;
      end
      if (fwd_eop) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.snk_ready         = adv;
  assign bus.src_valid         = src_valid_q;
  assign bus.src_startofpacket = src_sop_q;
  assign bus.src_endofpacket   = src_eop_q;
  assign bus.src_data          = bus.fx_data_out;

  video_effects_ctrl_regs #(
    .DW   (DW),
    .EFF_W(EFF_W),
    .CNT_W(CNT_W)
  ) u_regs (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs_address  (bus.avs_address),
    .avs_write    (bus.avs_write),
    .avs_writedata(bus.avs_writedata),
    .avs_read     (bus.avs_read),
    .avs_readdata (bus.avs_readdata),
    .commit       (commit),
    .sop_err_set  (sop_err_set),
    .irq_set      (fwd_eop),
    .in_frame     (state_q == StInFrame),
    .frame_cnt    (frame_cnt_q),
    .drop_cnt     (drop_cnt_q),
    .sh_eff       (sh_eff),
    .sh_en        (sh_en),
    .sh_delc      (sh_delc),
    .sh_subc      (sh_subc),
    .irq          (bus.irq)
  );

endmodule

// File: tb/tb_video_effects_ctrl.sv
// Directed bench for video_effects_ctrl with a frame-level reference model checked every cycle.
module tb_video_effects_ctrl;
  localparam int unsigned DW    = 16;
  localparam int unsigned EFF_W = 5;
`ifdef VIDEO_EFFECTS_CTRL_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif
  localparam logic [31:0] IrqSt = {14'd0, IrqEn, 17'd0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  video_effects_ctrl_if #(.DW(DW), .EFF_W(EFF_W)) bus ();

  video_effects_ctrl #(.DW(DW), .EFF_W(EFF_W), .CNT_W(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Stand-in datapath: substitute on colour match, then optional negate.
  function automatic logic [15:0] fx_f(logic [15:0] d, logic [4:0] eff, logic [15:0] dc,
                                       logic [15:0] sc);
    logic [15:0] r;
    r = d;
    if (eff[1] && d == dc) r = sc;
    if (eff[4]) r = ~r;
    return r;
  endfunction

  always @(posedge clk)
    bus.fx_data_out <= fx_f(bus.fx_data_in, bus.fx_effect, bus.fx_delete_color,
                            bus.fx_substitute_color);

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic [15:0] d; logic s; logic e;} beat_t;
  beat_t q[$];

  logic [4:0]  m_sh_eff, m_cm_eff;
  logic        m_sh_en, m_pending, m_in_frame, m_sop_err, m_irq, m_acc;
  logic [15:0] m_sh_delc, m_sh_subc, m_cm_delc, m_cm_subc, m_frame, m_drop;

  always @(negedge clk) begin
    logic adv, acc, fwd, sop, eop, irq_set, serr_set, clr17, clr18;
    logic [4:0] eff;
    logic [15:0] dc, sc;
    beat_t b;
    if (!reset_n) begin
      q.delete();
      {m_sh_eff, m_cm_eff, m_sh_en, m_pending, m_in_frame, m_sop_err, m_irq, m_acc} = '0;
      {m_sh_delc, m_sh_subc, m_cm_delc, m_cm_subc, m_frame, m_drop} = '0;
    end else begin
      chk("src_valid", {31'd0, bus.src_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("src_data", {16'd0, bus.src_data}, {16'd0, q[0].d});
        chk("src_sop", {31'd0, bus.src_startofpacket}, {31'd0, q[0].s});
        chk("src_eop", {31'd0, bus.src_endofpacket}, {31'd0, q[0].e});
      end
      chk("irq", {31'd0, bus.irq}, {31'd0, IrqEn & m_irq});
      adv = bus.src_ready || q.size() == 0;
      chk("snk_ready", {31'd0, bus.snk_ready}, {31'd0, adv});
      acc = bus.snk_valid && adv;
      sop = bus.snk_startofpacket;
      eop = bus.snk_endofpacket;
      irq_set = 1'b0;
      serr_set = 1'b0;
      if (adv && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        eff = sop ? (m_sh_en ? m_sh_eff : 5'd0) : m_cm_eff;
        dc  = sop ? m_sh_delc : m_cm_delc;
        sc  = sop ? m_sh_subc : m_cm_subc;
        chk("fx_effect", {27'd0, bus.fx_effect}, {27'd0, eff});
        chk("fx_delete_color", {16'd0, bus.fx_delete_color}, {16'd0, dc});
        fwd = m_in_frame || sop;
        if (fwd) begin
          b.d = fx_f(bus.snk_data, eff, dc, sc);
          b.s = sop;
          b.e = eop;
          q.push_back(b);
          if (sop && m_in_frame) serr_set = 1'b1;
          if (eop) begin
            m_frame++;
            irq_set = 1'b1;
          end
          m_in_frame = !eop;
        end else if (m_drop != 16'hFFFF) begin
          m_drop++;
        end
        if (sop) begin
          m_cm_eff  = eff;
          m_cm_delc = dc;
          m_cm_subc = sc;
          m_pending = 1'b0;
        end
      end
      clr17 = 1'b0;
      clr18 = 1'b0;
      if (bus.avs_write) begin
        case (bus.avs_address)
          2'd0: begin
            m_sh_eff  = bus.avs_writedata[4:0];
            m_sh_en   = bus.avs_writedata[8];
            m_pending = 1'b1;
          end
          2'd1: begin m_sh_delc = bus.avs_writedata[15:0]; m_pending = 1'b1; end
          2'd2: begin m_sh_subc = bus.avs_writedata[15:0]; m_pending = 1'b1; end
          default: begin clr17 = bus.avs_writedata[17]; clr18 = bus.avs_writedata[18]; end
        endcase
      end
      m_irq     = (m_irq & ~clr17) | irq_set;
      m_sop_err = (m_sop_err & ~clr18) | serr_set;
      m_acc     = acc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    step();
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    step();
    bus.avs_read = 1'b0;
    chk(name, bus.avs_readdata, exp);
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic e);
    int n;
    logic ok;
    bus.snk_data = d;
    bus.snk_startofpacket = s;
    bus.snk_endofpacket = e;
    bus.snk_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!m_acc && n < 50);
    ok = m_acc;
    #1;
    bus.snk_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.avs_address = '0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read = 1'b0;
    bus.snk_data = '0;
    bus.snk_startofpacket = 1'b0;
    bus.snk_endofpacket = 1'b0;
    bus.snk_valid = 1'b0;
    bus.src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", bus.avs_readdata, 32'd0);
    chk("rst_src_valid", {31'd0, bus.src_valid}, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    reset_n = 1'b1;
    step();
    rd(2'd0, 32'h0000_0000, "rst_ctrl");
    rd(2'd3, 32'h0000_0000, "rst_status");

    // Mid-frame config write leaves the current frame alone.
    send(16'h1000, 1'b1, 1'b0);
    wr(2'd0, 32'h0000_0110);
    rd(2'd0, 32'h8000_0110, "ctrl_pending");
    send(16'h1234, 1'b0, 1'b0);
    chk("old_frame_pix", {16'd0, bus.src_data}, 32'h0000_1234);
    send(16'h0001, 1'b0, 1'b1);
    send(16'h1234, 1'b1, 1'b0);
    chk("neg_sop_pix", {16'd0, bus.src_data}, 32'h0000_EDCB);
    rd(2'd0, 32'h0000_0110, "ctrl_committed");
    send(16'h0000, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1);

    // Backpressure for three cycles while beat 2 is held in the output stage.
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    bus.src_ready = 1'b0;
    bus.snk_data = 16'h0003;
    bus.snk_valid = 1'b1;
    repeat (3) begin
      step();
      chk("stall_data", {16'd0, bus.src_data}, 32'h0000_FFFD);
      chk("stall_valid", {31'd0, bus.src_valid}, 32'd1);
    end
    bus.src_ready = 1'b1;
    send(16'h0003, 1'b0, 1'b0);
    send(16'h0004, 1'b0, 1'b1);

    // Unframed beats are dropped and counted.
    send(16'hAAAA, 1'b0, 1'b0);
    send(16'hBBBB, 1'b0, 1'b0);
    send(16'hCCCC, 1'b0, 1'b0);
    send(16'h00FF, 1'b1, 1'b0);
    send(16'hFF00, 1'b0, 1'b1);
    rd(2'd3, 32'h0300_0004 | IrqSt, "status_drop");

    // Second SOP without EOP: commit at that SOP, flag sop_err, stay in frame.
    send(16'h0010, 1'b1, 1'b0);
    send(16'h0011, 1'b0, 1'b0);
    wr(2'd1, 32'h0000_5555);
    wr(2'd2, 32'h0000_00FF);
    wr(2'd0, 32'h0000_0112);
    send(16'h5555, 1'b1, 1'b0);
    chk("resop_pix", {16'd0, bus.src_data}, 32'h0000_FF00);
    rd(2'd3, 32'h0305_0004 | IrqSt, "status_sop_err");
    send(16'h0000, 1'b0, 1'b1);
    wr(2'd3, 32'h0006_0000);
    rd(2'd3, 32'h0300_0005, "status_w1c");

    // CTRL write on the SOP-accept cycle applies one frame later.
    bus.avs_address = 2'd0;
    bus.avs_writedata = 32'h0000_0000;
    bus.avs_write = 1'b1;
    send(16'h00F0, 1'b1, 1'b0);
    bus.avs_write = 1'b0;
    chk("race_sop_pix", {16'd0, bus.src_data}, 32'h0000_FF0F);
    rd(2'd0, 32'h8000_0000, "race_pending");
    send(16'h5555, 1'b0, 1'b1);
    chk("race_eop_pix", {16'd0, bus.src_data}, 32'h0000_FF00);
    send(16'h1234, 1'b1, 1'b0);
    chk("pass_pix", {16'd0, bus.src_data}, 32'h0000_1234);
    rd(2'd0, 32'h0000_0000, "race_done");
    send(16'h4321, 1'b0, 1'b1);
    chk("irq_set", {31'd0, bus.irq}, {31'd0, IrqEn});
    wr(2'd3, 32'h0002_0000);
    chk("irq_clr", {31'd0, bus.irq}, 32'd0);
    rd(2'd3, 32'h0000_0007 | 32'h0300_0000, "status_final");

    // Reset mid-frame: output discarded, tail of the frame dropped.
    send(16'h0100, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.src_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    send(16'h0101, 1'b0, 1'b1);
    rd(2'd3, 32'h0100_0000, "midrst_status");

    repeat (4) step();
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
